// File: rtl/object_recognition_if.sv
// Pixel-stream and centroid-result bundle for the object_recognition tracker.
// The master drives the tagged pixel stream; the slave returns the centroids and separations.
interface object_recognition_if;
  logic [1:0] color;
  logic [9:0] interesting_x;
  logic [8:0] interesting_y;
  logic       interesting_flag;
  logic       frame_flag;

  logic [9:0] a_x;
  logic [8:0] a_y;
  logic [9:0] b_x;
  logic [8:0] b_y;
  logic [9:0] c_x;
  logic [8:0] c_y;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic [9:0] m_x;
  logic [8:0] m_y;
  logic       corners_flag;

  modport master (
    output color, interesting_x, interesting_y, interesting_flag, frame_flag,
    input  a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y, m_x, m_y, corners_flag
  );

  modport slave (
    input  color, interesting_x, interesting_y, interesting_flag, frame_flag,
    output a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y, m_x, m_y, corners_flag
  );
endinterface

// File: rtl/object_recognition.sv
// Per-frame centroid tracker for four colour classes with pairwise minimum separation.
// Sums are divided by counts in eight parallel 10-step restoring dividers after each frame edge.
module object_recognition (
  input logic clk,
  input logic reset,
  object_recognition_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIVIDE, LOAD, MINDIST} state_t;

  logic        r_framePrev;
  logic [18:0] r_cnt [4];
  logic [28:0] r_sx [4];
  logic [27:0] r_sy [4];

  state_t      r_state;
  logic [3:0]  r_step;
  logic [18:0] r_div [4];
  logic        r_zero [4];
  logic [18:0] r_rem [8];
  logic [9:0]  r_dq [8];
  logic        r_ovf [8];

  logic [9:0]  r_cx [4];
  logic [8:0]  r_cy [4];
  logic [9:0]  r_mx;
  logic [8:0]  r_my;
  logic        r_corners;

  logic        w_frameRise;
  logic [19:0] w_trial [8];
  logic [18:0] w_diff [8];
  logic        w_fit [8];
  logic [9:0]  w_qx [4];
  logic [8:0]  w_qy [4];
  logic [9:0]  w_minX;
  logic [8:0]  w_minY;

  assign w_frameRise = bus.frame_flag & ~r_framePrev;

  function automatic logic [9:0] absX(input logic [9:0] p, input logic [9:0] q);
    return (p > q) ? (p - q) : (q - p);
  endfunction

  function automatic logic [8:0] absY(input logic [8:0] p, input logic [8:0] q);
    return (p > q) ? (p - q) : (q - p);
  endfunction

  // Accumulators restart on every frame edge, seeded with the boundary pixel if one is present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_framePrev <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        r_cnt[c] <= '0;
        r_sx[c]  <= '0;
        r_sy[c]  <= '0;
      end
    end else begin
      r_framePrev <= bus.frame_flag;
      for (int c = 0; c < 4; c++) begin
        if (w_frameRise) begin
          if (bus.interesting_flag && (bus.color == c[1:0])) begin
            r_cnt[c] <= 19'd1;
            r_sx[c]  <= {19'd0, bus.interesting_x};
            r_sy[c]  <= {19'd0, bus.interesting_y};
          end else begin
            r_cnt[c] <= '0;
            r_sx[c]  <= '0;
            r_sy[c]  <= '0;
          end
        end else if (bus.interesting_flag && (bus.color == c[1:0])) begin
          r_cnt[c] <= r_cnt[c] + 19'd1;
          r_sx[c]  <= r_sx[c] + {19'd0, bus.interesting_x};
          r_sy[c]  <= r_sy[c] + {19'd0, bus.interesting_y};
        end
      end
    end
  end

  // Lanes 0..3 divide x sums, lanes 4..7 divide y sums; the remainder never exceeds the divisor,
  // so the 19-bit modular subtraction is exact whenever the trial fits.
  always_comb begin
    for (int l = 0; l < 8; l++) begin
      w_trial[l] = {r_rem[l], r_dq[l][9]};
      w_fit[l]   = (w_trial[l] >= {1'b0, r_div[l[1:0]]});
      w_diff[l]  = w_trial[l][18:0] - r_div[l[1:0]];
    end
    for (int c = 0; c < 4; c++) begin
      if (r_zero[c])
        w_qx[c] = '0;
      else if (r_ovf[c])
        w_qx[c] = 10'h3FF;
      else
        w_qx[c] = r_dq[c];
      if (r_zero[c])
        w_qy[c] = '0;
      else if (r_ovf[c+4] || r_dq[c+4][9])
        w_qy[c] = 9'h1FF;
      else
        w_qy[c] = r_dq[c+4][8:0];
    end
  end

  always_comb begin
    w_minX = 10'h3FF;
    w_minY = 9'h1FF;
    for (int i = 0; i < 3; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (absX(r_cx[i], r_cx[j]) < w_minX) w_minX = absX(r_cx[i], r_cx[j]);
        if (absY(r_cy[i], r_cy[j]) < w_minY) w_minY = absY(r_cy[i], r_cy[j]);
      end
    end
  end

  // Snapshot is taken only when idle, so a second frame edge mid-division cannot corrupt it.
  // The high sum bits start as the partial remainder; if they already reach the divisor
  // the quotient cannot fit and the lane saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_step    <= '0;
      r_mx      <= '0;
      r_my      <= '0;
      r_corners <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        r_div[c]  <= '0;
        r_zero[c] <= 1'b0;
        r_cx[c]   <= '0;
        r_cy[c]   <= '0;
      end
      for (int l = 0; l < 8; l++) begin
        r_rem[l] <= '0;
        r_dq[l]  <= '0;
        r_ovf[l] <= 1'b0;
      end
    end else begin
      r_corners <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_frameRise) begin
            for (int c = 0; c < 4; c++) begin
              r_div[c]    <= r_cnt[c];
              r_zero[c]   <= (r_cnt[c] == 19'd0);
              r_rem[c]    <= r_sx[c][28:10];
              r_dq[c]     <= r_sx[c][9:0];
              r_ovf[c]    <= (r_sx[c][28:10] >= r_cnt[c]);
              r_rem[c+4]  <= {1'b0, r_sy[c][27:10]};
              r_dq[c+4]   <= r_sy[c][9:0];
              r_ovf[c+4]  <= ({1'b0, r_sy[c][27:10]} >= r_cnt[c]);
            end
            r_step  <= '0;
            r_state <= DIVIDE;
          end
        end
        DIVIDE: begin
          for (int l = 0; l < 8; l++) begin
            r_rem[l] <= w_fit[l] ? w_diff[l] : w_trial[l][18:0];
            r_dq[l]  <= {r_dq[l][8:0], w_fit[l]};
          end
          r_step <= r_step + 4'd1;
          if (r_step == 4'd9) r_state <= LOAD;
        end
        LOAD: begin
          for (int c = 0; c < 4; c++) begin
            r_cx[c] <= w_qx[c];
            r_cy[c] <= w_qy[c];
          end
          r_state <= MINDIST;
        end
        MINDIST: begin
          r_mx      <= w_minX;
          r_my      <= w_minY;
          r_corners <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a_x          = r_cx[0];
  assign bus.a_y          = r_cy[0];
  assign bus.b_x          = r_cx[1];
  assign bus.b_y          = r_cy[1];
  assign bus.c_x          = r_cx[2];
  assign bus.c_y          = r_cy[2];
  assign bus.d_x          = r_cx[3];
  assign bus.d_y          = r_cy[3];
  assign bus.m_x          = r_mx;
  assign bus.m_y          = r_my;
  assign bus.corners_flag = r_corners;

endmodule

// File: tb/tb_object_recognition.sv
// Directed bench for object_recognition: a behavioural model pushes expected centroids
// at each frame edge and they are popped and compared when corners_flag pulses.
module tb_object_recognition;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   pulses;

  int   mCnt [4];
  int   mSx [4];
  int   mSy [4];
  bit   prevFrame;
  int   expQ [$];

  object_recognition_if bus ();

  object_recognition dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.corners_flag === 1'b1) pulses++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int c = 0; c < 4; c++) begin
      mCnt[c] = 0;
      mSx[c]  = 0;
      mSy[c]  = 0;
    end
  endtask

  // Floor division with saturation, cnt=0 giving 0, then minimum pairwise separation.
  task automatic pushExpected();
    int qx [4];
    int qy [4];
    int mx;
    int my;
    int d;
    for (int c = 0; c < 4; c++) begin
      if (mCnt[c] == 0) begin
        qx[c] = 0;
        qy[c] = 0;
      end else begin
        qx[c] = mSx[c] / mCnt[c];
        qy[c] = mSy[c] / mCnt[c];
        if (qx[c] > 1023) qx[c] = 1023;
        if (qy[c] > 511) qy[c] = 511;
      end
      expQ.push_back(qx[c]);
      expQ.push_back(qy[c]);
    end
    mx = 1023;
    my = 511;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i != j) begin
          d = (qx[i] > qx[j]) ? qx[i] - qx[j] : qx[j] - qx[i];
          if (d < mx) mx = d;
          d = (qy[i] > qy[j]) ? qy[i] - qy[j] : qy[j] - qy[i];
          if (d < my) my = d;
        end
      end
    end
    expQ.push_back(mx);
    expQ.push_back(my);
  endtask

  task automatic applyStimulus(input bit fl, input bit intr, input int col, input int x, input int y);
    @(negedge clk);
    bus.frame_flag       = fl;
    bus.interesting_flag = intr;
    bus.color            = col[1:0];
    bus.interesting_x    = x[9:0];
    bus.interesting_y    = y[8:0];
    if (fl && !prevFrame) begin
      pushExpected();
      clearModel();
      if (intr) begin
        mCnt[col] = 1;
        mSx[col]  = x;
        mSy[col]  = y;
      end
    end else if (intr) begin
      mCnt[col] += 1;
      mSx[col]  += x;
      mSy[col]  += y;
    end
    prevFrame = fl;
  endtask

  // Waits for the pulse after a frame edge driven by applyStimulus, then checks the popped result.
  task automatic checkFrame(input string tag);
    int  k;
    bit  found;
    int  e [10];
    found = 1'b0;
    k     = 0;
    @(posedge clk);
    #1;
    bus.interesting_flag = 1'b0;
    while (!found && k < 50) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.corners_flag === 1'b1) found = 1'b1;
    end
    checkOutput({tag, "_seen"}, int'(found), 1);
    if (found) checkOutput({tag, "_latency"}, k, 12);
    for (int i = 0; i < 10; i++) e[i] = (expQ.size() > 0) ? expQ.pop_front() : -1;
    checkOutput({tag, "_a_x"}, int'(bus.a_x), e[0]);
    checkOutput({tag, "_a_y"}, int'(bus.a_y), e[1]);
    checkOutput({tag, "_b_x"}, int'(bus.b_x), e[2]);
    checkOutput({tag, "_b_y"}, int'(bus.b_y), e[3]);
    checkOutput({tag, "_c_x"}, int'(bus.c_x), e[4]);
    checkOutput({tag, "_c_y"}, int'(bus.c_y), e[5]);
    checkOutput({tag, "_d_x"}, int'(bus.d_x), e[6]);
    checkOutput({tag, "_d_y"}, int'(bus.d_y), e[7]);
    checkOutput({tag, "_m_x"}, int'(bus.m_x), e[8]);
    checkOutput({tag, "_m_y"}, int'(bus.m_y), e[9]);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_a_x"}, int'(bus.a_x), 0);
    checkOutput({tag, "_b_x"}, int'(bus.b_x), 0);
    checkOutput({tag, "_b_y"}, int'(bus.b_y), 0);
    checkOutput({tag, "_d_y"}, int'(bus.d_y), 0);
    checkOutput({tag, "_m_x"}, int'(bus.m_x), 0);
    checkOutput({tag, "_m_y"}, int'(bus.m_y), 0);
    checkOutput({tag, "_corners"}, int'(bus.corners_flag), 0);
  endtask

  // Asserts reset between edges and drops the inputs so release does not look like a frame edge.
  task automatic asyncReset(input string tag);
    @(negedge clk);
    #2;
    reset                = 1'b1;
    bus.frame_flag       = 1'b0;
    bus.interesting_flag = 1'b0;
    prevFrame            = 1'b0;
    clearModel();
    #1;
    checkCleared(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    checks               = 0;
    errors               = 0;
    pulses               = 0;
    prevFrame            = 1'b0;
    reset                = 1'b1;
    bus.frame_flag       = 1'b0;
    bus.interesting_flag = 1'b0;
    bus.color            = 2'd0;
    bus.interesting_x    = '0;
    bus.interesting_y    = '0;
    clearModel();
    repeat (3) @(posedge clk);
    #1;
    checkCleared("reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] centroid and minimum distance");
    for (int i = 0; i < 20; i++)
      for (int c = 0; c < 4; c++)
        applyStimulus(1'b0, 1'b1, c, i * (c + 1), i * (c + 1));
    p0 = pulses;
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkFrame("ramp");
    repeat (20) @(negedge clk);
    checkOutput("ramp_single_pulse", pulses - p0, 1);

    $display("[TB] asynchronous reset with live outputs");
    asyncReset("async_reset");

    $display("[TB] empty colours and boundary pixel");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 0, 100, 50);
    p0 = pulses;
    applyStimulus(1'b1, 1'b1, 1, 10, 10);
    checkFrame("empty");
    repeat (86) @(negedge clk);
    checkOutput("held_single_pulse", pulses - p0, 1);
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkFrame("boundary");

    $display("[TB] reset during division");
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 2, 200, 100);
      applyStimulus(1'b0, 1'b1, 3, 300, 150);
    end
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 10; i++) void'(expQ.pop_front());
    @(posedge clk);
    repeat (4) @(posedge clk);
    p0 = pulses;
    asyncReset("abort");
    repeat (30) @(negedge clk);
    checkOutput("abort_no_pulse", pulses - p0, 0);

    $display("[TB] frame after aborted division");
    applyStimulus(1'b0, 1'b1, 0, 5, 7);
    applyStimulus(1'b0, 1'b1, 0, 8, 9);
    applyStimulus(1'b0, 1'b1, 1, 50, 60);
    applyStimulus(1'b0, 1'b1, 2, 70, 90);
    applyStimulus(1'b0, 1'b1, 3, 600, 400);
    applyStimulus(1'b0, 1'b1, 3, 601, 401);
    applyStimulus(1'b1, 1'b0, 0, 0, 0);
    checkFrame("recover");
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/object_recognition.md
Name: object_recognition

Overview:
Per-frame centroid tracker for four colour-tagged marker classes in the AR pipeline. It accumulates the coordinates of "interesting" pixels per colour (0..3) over a frame. At each frame boundary it divides the sums by the counts to produce four corner centroids A..D. It also reports the minimum pairwise x and y centroid separations (m_x, m_y) and pulses corners_flag when all outputs are fresh.

Parameters:
None; coordinate widths are fixed at 10 bits (x) and 9 bits (y).

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
color  input  2  colour class of current pixel: 0->A, 1->B, 2->C, 3->D
interesting_x  input  10  pixel x coordinate
interesting_y  input  9  pixel y coordinate
interesting_flag  input  1  pixel valid/interesting this cycle
frame_flag  input  1  frame boundary indicator (level; rising edge acts)
a_x/a_y, b_x/b_y, c_x/c_y, d_x/d_y  output  10/9 each  centroid of colour 0/1/2/3
m_x  output  10  min |xi-xj| over the 6 centroid pairs
m_y  output  9  min |yi-yj| over the 6 centroid pairs
corners_flag  output  1  one-cycle pulse: new centroids and m_x/m_y valid

Behaviour:
- Reset (async, active-high): all accumulators, divider state, frame_flag history register, outputs and corners_flag go to 0.
- Per colour c, three accumulators: cnt[c] (19 b), sx[c] (29 b), sy[c] (28 b).
- On each edge with interesting_flag=1: cnt[color]+=1, sx[color]+=interesting_x, sy[color]+=interesting_y.
- Accumulators wrap modulo their width. Widths cover a full 640x480 frame.
- Frame boundary: on an edge where frame_flag=1 and its registered previous value was 0 (edge N):
  - all 12 accumulators are snapshotted into the divider;
  - accumulators restart. If interesting_flag=1 on edge N, they are loaded with that pixel (cnt=1, sums = coordinates); otherwise they are cleared.
- Holding frame_flag high does nothing further. Another rising edge during a division is ignored for snapshot purposes but still restarts the accumulators.
- Division: 8 parallel restoring dividers (sx[c]/cnt[c], sy[c]/cnt[c]), unsigned, floor.
  - Quotient is 10 bits for x and 9 bits for y; it saturates to all-ones if it overflows.
  - cnt=0 gives quotient 0.
  - Iterations on edges N+1..N+10.
  - a..d outputs update together on edge N+11 and hold until the next update.
- m_x/m_y register on edge N+12 from the new centroids. corners_flag=1 for exactly the cycle after edge N+12; otherwise 0.
- Total latency from the frame_flag rise to corners_flag is 12 clocks, well under 50.
- Reset mid-division: the division is aborted, no corners_flag pulse is produced, and outputs are 0.

Test Plan:
- Reset: assert reset asynchronously between edges -> all outputs and corners_flag read 0 immediately.
- Centroid/min distance: for i=0..19, one pixel per cycle per colour with int=1: colour0 at (i,i), colour1 at (2i,2i), colour2 at (3i,3i), colour3 at (4i,4i). Then raise frame_flag and hold -> within 50 cycles a=(9,9), b=(19,19), c=(28,28), d=(38,38), m_x=9, m_y=9. corners_flag pulses exactly once, 12 clocks after the rise.
- Empty colour: frame with pixels only for colour 0 at (100,50) x4 -> a=(100,50), b=c=d=(0,0), m_x=0, m_y=0.
- Boundary pixel: interesting_flag=1 with colour1 at (10,10) on the frame_flag rising edge. Next frame has no other colour1 pixels -> next b=(10,10).
- Held frame_flag: frame_flag high for 100 cycles -> a single corners_flag pulse only.
- Reset at N+5 during division -> no corners_flag pulse, outputs 0; the next frame computes correctly.
